padlock_sequencer: RTL and testbench

//   Controller for the button combination padlock. Edge-detects the digit and open buttons and sequences code entry.

---
 rtl/padlock_pkg.sv | 46 ++++
 rtl/padlock_edge_detect.sv | 20 ++
 rtl/padlock_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_padlock_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/padlock_pkg.sv
// Shared types, constants and helpers for the button combination padlock.
package padlock_pkg;

    localparam int CODE_LEN = 4;
    localparam int DIGIT_W  = 2;
    localparam int NUM_BUT  = 1 << DIGIT_W;
    localparam int CODE_W   = CODE_LEN * DIGIT_W;
    localparam int IDX_W    = $clog2(CODE_LEN + 1);
    localparam logic [CODE_W-1:0] DEFAULT_CODE = 8'h36;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        FAIL,
        UNLOCKED,
        LOCKOUT,
        PROGRAM
    } state_t;

    // One shared timer serves every timed state, so it is sized for the longest interval.
    function automatic int cnt_width(input int a, input int b, input int c);
        int w;
        w = $clog2(a);
        if ($clog2(b) > w) w = $clog2(b);
        if ($clog2(c) > w) w = $clog2(c);
        return w;
    endfunction

    function automatic logic [DIGIT_W-1:0] first_digit(input logic [NUM_BUT-1:0] rise);
        first_digit = '0;
        for (int i = NUM_BUT - 1; i >= 0; i--) begin
            if (rise[i]) first_digit = DIGIT_W'(i);
        end
    endfunction

    function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] digits,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic [DIGIT_W-1:0] value);
        put_digit = digits;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == IDX_W'(i)) put_digit[i*DIGIT_W +: DIGIT_W] = value;
        end
    endfunction

endpackage

// File: rtl/padlock_edge_detect.sv
// Rising-edge detector; previous values reset to 1 so buttons held through reset never fire.
module padlock_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (!reset_n) prev <= '1;
        else          prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/padlock_sequencer.sv
// Padlock controller: code entry, check, unlock hold, entry timeout and failure lockout.
// Defining PADLOCK_PROGRAM_EN adds the prog button and the PROGRAM state for changing the code.
module padlock_sequencer
    import padlock_pkg::*;
#(
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int UNLOCK_CYC  = 500,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BUT-1:0] but,
    input  logic               open,
`ifdef PADLOCK_PROGRAM_EN
    input  logic               prog,
`endif
    output logic               lock,
    output logic               locked_out,
    output logic               fail_pulse,
    output logic [1:0]         fail_count
);

    localparam int CNT_W = cnt_width(LOCKOUT_CYC, UNLOCK_CYC, TIMEOUT_CYC);

`ifdef PADLOCK_PROGRAM_EN
    localparam int EV_W = NUM_BUT + 2;
`else
    localparam int EV_W = NUM_BUT + 1;
`endif

    state_t              state, state_n;
    logic [CODE_W-1:0]   digits, digits_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic                ovf, ovf_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [1:0]          fail_cnt_n;
    logic [CODE_W-1:0]   code;
    logic [EV_W-1:0]     ev_level, rise;
    logic                digit_ev, open_ev, match;
    logic [DIGIT_W-1:0]  digit;

`ifdef PADLOCK_PROGRAM_EN
    logic [CODE_W-1:0]   code_n;
    logic                prog_ev;

    assign ev_level = {prog, open, but};
    assign prog_ev  = rise[NUM_BUT+1];
`else
    assign ev_level = {open, but};
    assign code     = DEFAULT_CODE;
`endif

    padlock_edge_detect #(.WIDTH(EV_W)) u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (ev_level),
        .rise    (rise)
    );

    assign digit_ev   = |rise[NUM_BUT-1:0];
    assign digit      = first_digit(rise[NUM_BUT-1:0]);
    assign open_ev    = rise[NUM_BUT];
    assign match      = (idx == IDX_W'(CODE_LEN)) && !ovf && (digits == code);
    assign locked_out = (state == LOCKOUT);
    assign fail_pulse = (state == FAIL);

    // The timer idles at zero; only the timed states keep it running.
    always_comb begin
        state_n    = state;
        digits_n   = digits;
        idx_n      = idx;
        ovf_n      = ovf;
        cnt_n      = '0;
        fail_cnt_n = fail_count;
`ifdef PADLOCK_PROGRAM_EN
        code_n     = code;
`endif
        case (state)
            IDLE: begin
                if (digit_ev) begin
                    digits_n = put_digit('0, '0, digit);
                    idx_n    = IDX_W'(1);
                    ovf_n    = 1'b0;
                    state_n  = open_ev ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                if (digit_ev) begin
                    if (idx == IDX_W'(CODE_LEN)) begin
                        ovf_n = 1'b1;
                    end else begin
                        digits_n = put_digit(digits, idx, digit);
                        idx_n    = idx + IDX_W'(1);
                    end
                end
                if (open_ev) begin
                    state_n = CHECK;
                end else if (!digit_ev) begin
                    if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        digits_n = '0;
                        idx_n    = '0;
                        ovf_n    = 1'b0;
                        state_n  = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                digits_n = '0;
                idx_n    = '0;
                ovf_n    = 1'b0;
                if (match) begin
                    state_n    = UNLOCKED;
                    fail_cnt_n = '0;
                end else begin
                    state_n    = FAIL;
                    fail_cnt_n = (&fail_count) ? fail_count : fail_count + 2'd1;
                end
            end
            FAIL: begin
                state_n = (int'(fail_count) >= MAX_FAILS) ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                if (cnt == CNT_W'(LOCKOUT_CYC - 1)) begin
                    state_n    = IDLE;
                    fail_cnt_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            UNLOCKED: begin
                if (cnt == CNT_W'(UNLOCK_CYC - 1)) state_n = IDLE;
                else                               cnt_n   = cnt + CNT_W'(1);
`ifdef PADLOCK_PROGRAM_EN
                if (prog_ev) begin
                    state_n = PROGRAM;
                    cnt_n   = '0;
                end
`endif
            end
`ifdef PADLOCK_PROGRAM_EN
            PROGRAM: begin
                if (digit_ev) begin
                    digits_n = put_digit(digits, idx, digit);
                    idx_n    = idx + IDX_W'(1);
                    if (idx == IDX_W'(CODE_LEN - 1)) begin
                        code_n   = digits_n;
                        digits_n = '0;
                        idx_n    = '0;
                        state_n  = IDLE;
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    digits_n = '0;
                    idx_n    = '0;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            digits     <= '0;
            idx        <= '0;
            ovf        <= 1'b0;
            cnt        <= '0;
            fail_count <= '0;
            lock       <= 1'b1;
        end else begin
            state      <= state_n;
            digits     <= digits_n;
            idx        <= idx_n;
            ovf        <= ovf_n;
            cnt        <= cnt_n;
            fail_count <= fail_cnt_n;
            lock       <= (state_n != UNLOCKED);
        end
    end

`ifdef PADLOCK_PROGRAM_EN
    always_ff @(posedge clk) begin
        if (!reset_n) code <= DEFAULT_CODE;
        else          code <= code_n;
    end
`endif

endmodule

// File: tb/tb_padlock_sequencer.sv
// Bench for padlock_sequencer: a timestamped behavioural model predicts output events into a queue
// that an independent negedge monitor drains.
module tb_padlock_sequencer;

    localparam int UNLOCK_CYC  = 500;
    localparam int LOCKOUT_CYC = 1000;
    localparam int TIMEOUT_CYC = 2000;
    localparam int MAX_FAILS   = 3;
`ifdef PADLOCK_PROGRAM_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif
    localparam int W = 32;

    localparam int EV_LOCK_FALL   = 1;
    localparam int EV_LOCK_RISE   = 2;
    localparam int EV_FAIL        = 3;
    localparam int EV_LOCKOUT_ON  = 4;
    localparam int EV_LOCKOUT_OFF = 5;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_VERDICT = 2, M_FAILED = 3;
    localparam int M_OPEN = 4, M_BARRED = 5, M_PROG = 6;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] but = 4'b0;
    logic       open = 1'b0;
`ifdef PADLOCK_PROGRAM_EN
    logic       prog = 1'b0;
`endif
    logic       lock, locked_out, fail_pulse;
    logic [1:0] fail_count;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    padlock_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .but        (but),
        .open       (open),
`ifdef PADLOCK_PROGRAM_EN
        .prog       (prog),
`endif
        .lock       (lock),
        .locked_out (locked_out),
        .fail_pulse (fail_pulse),
        .fail_count (fail_count)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] mk_ev(input int ev, input logic [1:0] fc, input int stamp);
        return {4'(ev), fc, 26'(stamp)};
    endfunction

    task automatic push_ev(input int ev, input int fc, input int stamp);
        exp_q.push_back(mk_ev(ev, 2'(fc), stamp));
    endtask

    task automatic observe(input int ev);
        logic [W-1:0] got, want;
        got = mk_ev(ev, fail_count, cyc);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got ev=%0d fc=%0d edge=%0d, required none",
                     got[31:28], got[27:26], got[25:0]);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL event: got ev=%0d fc=%0d edge=%0d, required ev=%0d fc=%0d edge=%0d",
                         got[31:28], got[27:26], got[25:0], want[31:28], want[27:26], want[25:0]);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    bit   mon_en = 1'b0;
    logic prev_lock = 1'b1;
    logic prev_lo = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (lock !== prev_lock) observe(lock === 1'b1 ? EV_LOCK_RISE : EV_LOCK_FALL);
            if (fail_pulse === 1'b1) observe(EV_FAIL);
            if (locked_out !== prev_lo) observe(locked_out === 1'b1 ? EV_LOCKOUT_ON : EV_LOCKOUT_OFF);
            prev_lock = lock;
            prev_lo   = locked_out;
        end
    end

    // ---------------- behavioural reference model ----------------
    int m_mode = M_IDLE;
    int m_entry[$];
    int m_code[4] = '{2, 1, 3, 0};
    int m_fails = 0;
    int m_until = 0;
    int m_last = 0;

    function automatic bit code_matches();
        if (m_entry.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_entry[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Advances the model across clock edge k given the button edges the bench created for it.
    task automatic model_step(input int k, input bit rst, input bit [3:0] dr, input bit orr, input bit pr);
        int d;
        d = -1;
        for (int i = 3; i >= 0; i--) if (dr[i]) d = i;
        if (rst) begin
            if (m_mode == M_OPEN)   push_ev(EV_LOCK_RISE, 0, k);
            if (m_mode == M_BARRED) push_ev(EV_LOCKOUT_OFF, 0, k);
            m_mode  = M_IDLE;
            m_entry.delete();
            m_fails = 0;
            m_code  = '{2, 1, 3, 0};
        end else begin
            case (m_mode)
                M_IDLE: if (d >= 0) begin
                    m_entry.delete();
                    m_entry.push_back(d);
                    m_last = k;
                    m_mode = orr ? M_VERDICT : M_ENTRY;
                end
                M_ENTRY: begin
                    if (d >= 0) begin
                        m_entry.push_back(d);
                        m_last = k;
                    end
                    if (orr) m_mode = M_VERDICT;
                    else if (k - m_last >= TIMEOUT_CYC) begin
                        m_entry.delete();
                        m_mode = M_IDLE;
                    end
                end
                M_VERDICT: begin
                    if (code_matches()) begin
                        m_fails = 0;
                        m_mode  = M_OPEN;
                        m_until = k + UNLOCK_CYC;
                        push_ev(EV_LOCK_FALL, 0, k);
                    end else begin
                        m_fails = (m_fails < 3) ? m_fails + 1 : 3;
                        m_mode  = M_FAILED;
                        push_ev(EV_FAIL, m_fails, k);
                    end
                    m_entry.delete();
                end
                M_FAILED: begin
                    if (m_fails >= MAX_FAILS) begin
                        m_mode  = M_BARRED;
                        m_until = k + LOCKOUT_CYC;
                        push_ev(EV_LOCKOUT_ON, m_fails, k);
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
                M_BARRED: if (k >= m_until) begin
                    m_mode  = M_IDLE;
                    m_fails = 0;
                    push_ev(EV_LOCKOUT_OFF, 0, k);
                end
                M_OPEN: begin
                    if (pr) begin
                        m_mode = M_PROG;
                        m_last = k;
                        m_entry.delete();
                        push_ev(EV_LOCK_RISE, 0, k);
                    end else if (k >= m_until) begin
                        m_mode = M_IDLE;
                        push_ev(EV_LOCK_RISE, 0, k);
                    end
                end
                M_PROG: begin
                    if (d >= 0) begin
                        m_entry.push_back(d);
                        m_last = k;
                        if (m_entry.size() == 4) begin
                            for (int i = 0; i < 4; i++) m_code[i] = m_entry[i];
                            m_entry.delete();
                            m_mode = M_IDLE;
                        end
                    end else if (k - m_last >= TIMEOUT_CYC) begin
                        m_entry.delete();
                        m_mode = M_IDLE;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // ---------------- driver tasks ----------------
    logic [5:0] drv_prev = '1;

    // Called at a negedge: drives levels for the next posedge and tells the model what edges they make.
    task automatic tick(input bit rst, input logic [3:0] b, input logic o, input logic p);
        logic [5:0] lvl, rise;
        lvl  = {p, o, b};
        rise = rst ? 6'b0 : (lvl & ~drv_prev);
        reset_n = !rst;
        but     = b;
        open    = o;
`ifdef PADLOCK_PROGRAM_EN
        prog    = p;
`endif
        model_step(cyc + 1, rst, rise[3:0], rise[4], rise[5] && PROG_EN);
        drv_prev = rst ? 6'h3f : lvl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [3:0] b);
        tick(1'b0, b, 1'b0, 1'b0);
        tick(1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic digit(input int d);
        press(4'(1 << d));
    endtask

    task automatic press_open();
        tick(1'b0, 4'b0, 1'b1, 1'b0);
        tick(1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic code4(input int a, input int b, input int c, input int e);
        digit(a); digit(b); digit(c); digit(e);
        press_open();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kind, n, hold;
        logic [3:0] bm;

        @(negedge clk);
        repeat (3) tick(1'b1, 4'b0, 1'b0, 1'b0);
        check_val("reset_lock", {1'b0, lock}, 2'd1);
        check_val("reset_locked_out", {1'b0, locked_out}, 2'd0);
        check_val("reset_fail_pulse", {1'b0, fail_pulse}, 2'd0);
        check_val("reset_fail_count", fail_count, 2'd0);
        mon_en = 1'b1;

        // Correct code opens for the full hold time.
        code4(2, 1, 3, 0);
        idle(UNLOCK_CYC + 10);

        // Three wrong codes lock out; the correct code during lockout is ignored.
        for (int i = 0; i < 3; i++) begin
            code4(2, 1, 3, 1);
            idle(5);
        end
        code4(2, 1, 3, 0);
        idle(LOCKOUT_CYC);

        // Overflowing and short entries fail; a good code then clears the count.
        digit(2); digit(1); digit(3); digit(0); digit(0); press_open();
        idle(5);
        digit(2); digit(1); digit(3); press_open();
        idle(5);
        code4(2, 1, 3, 0);
        idle(UNLOCK_CYC + 10);

        // Entry timeout discards the partial code without counting a failure.
        digit(2); digit(1);
        idle(TIMEOUT_CYC + 5);
        digit(3); digit(0); press_open();
        idle(5);
        code4(2, 1, 3, 0);
        idle(UNLOCK_CYC + 10);

        // Simultaneous buttons store the lowest digit; digit and open in one cycle take the digit first.
        digit(2); press(4'b0110); digit(3); digit(0); press_open();
        idle(UNLOCK_CYC + 10);
        digit(2); digit(1); digit(3);
        tick(1'b0, 4'b0001, 1'b1, 1'b0);
        idle(UNLOCK_CYC + 10);

        // A button held through reset release stores nothing; reset while open relocks at once.
        tick(1'b0, 4'b0100, 1'b0, 1'b0);
        repeat (2) tick(1'b1, 4'b0100, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 4'b0100, 1'b0, 1'b0);
        idle(1);
        code4(2, 1, 3, 0);
        idle(100);
        repeat (2) tick(1'b1, 4'b0, 1'b0, 1'b0);
        idle(5);

`ifdef PADLOCK_PROGRAM_EN
        // Reprogram to 0,0,1,1, then confirm a program timeout keeps that code.
        code4(2, 1, 3, 0);
        idle(10);
        tick(1'b0, 4'b0, 1'b0, 1'b1);
        idle(1);
        digit(0); digit(0); digit(1); digit(1);
        idle(5);
        code4(2, 1, 3, 0);
        idle(5);
        code4(0, 0, 1, 1);
        idle(10);
        tick(1'b0, 4'b0, 1'b0, 1'b1);
        idle(1);
        digit(2); digit(1);
        idle(TIMEOUT_CYC + 5);
        code4(0, 0, 1, 1);
        idle(UNLOCK_CYC + 10);
`endif

        // Randomised attempts: correct codes, wrong lengths, multi-button chords, held buttons.
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            n = (kind == 0) ? 4 : $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                if (kind == 0) bm = 4'(1 << m_code[j]);
                else           bm = 4'($urandom_range(1, 15));
                hold = $urandom_range(1, 3);
                for (int h = 0; h < hold; h++) tick(1'b0, bm, 1'b0, 1'b0);
                idle($urandom_range(1, 4));
            end
            press_open();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(2, 600));
            else                           idle($urandom_range(2, 40));
        end

        idle(LOCKOUT_CYC + UNLOCK_CYC + 10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d events still expected, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
